// File: rtl/interval_decode.sv
// interval_decode: maps a one-hot interval code back to its bin centroid.
// The centroids live in a small programmable table that the configuration
// port writes. Lookups flow through a two-stage valid/ready pipeline:
//   stage A: captures the bin index and a not-one-hot error flag
//   stage B: reads the table and presents the value to the consumer
// A code that is not one-hot decodes to zero with err_o set. err_cnt_o
// counts delivered errored codes and saturates at its maximum.
module interval_decode #(
  // FP format encoding: 0=FP32, 1=FP64, 2=FP16, 3=FP8, 4=FP16ALT
  parameter int FpFormat = 3,
  parameter int NUM      = 8,
  parameter int CNTW     = 8,
  localparam int WIDTH   = (FpFormat == 0) ? 32 :
                           (FpFormat == 1) ? 64 :
                           (FpFormat == 2) ? 16 :
                           (FpFormat == 3) ? 8  : 16,
  localparam int IDXW    = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_we_i,
  input  logic [IDXW-1:0]  cfg_addr_i,
  input  logic [WIDTH-1:0] cfg_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [NUM-1:0]   interval_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] value_o,
  output logic             err_o,
  output logic [CNTW-1:0]  err_cnt_o
);

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // valid and ready are both high. A producer holding valid keeps its data
  // stable until that transfer. Ready is derived only from the stage valids
  // downstream and out_ready_i, never from in_valid_i, so there is no
  // combinational valid->ready path.

  localparam int AW1 = IDXW + 1;

  logic [WIDTH-1:0] tbl [NUM];

  logic             a_valid;
  logic [IDXW-1:0]  a_idx;
  logic             a_err;
  logic             b_valid;
  logic [WIDTH-1:0] b_value;
  logic             b_err;
  logic [CNTW-1:0]  err_cnt;

  logic             a_ready;
  logic             b_ready;
  logic [IDXW-1:0]  a_idx_c;
  logic             a_err_c;
  logic             cfg_hit;

  assign b_ready = !b_valid || out_ready_i;
  assign a_ready = !a_valid || b_ready;

  // Bin index of the set bit; a malformed code is flagged and forced to bin 0.
  always_comb begin
    a_idx_c = '0;
    for (int i = 0; i < NUM; i++) begin
      if (interval_i[i]) a_idx_c = IDXW'(i);
    end
    a_err_c = !$onehot(interval_i);
    if (a_err_c) a_idx_c = '0;
  end

  // Addresses beyond the last bin are dropped rather than aliased.
  assign cfg_hit = cfg_we_i && ({1'b0, cfg_addr_i} < AW1'(NUM));

  // Centroid table; a same-edge write and lookup returns the old entry because
  // stage B samples the table before this update lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM; i++) tbl[i] <= '0;
    end else if (cfg_hit) begin
      tbl[cfg_addr_i] <= cfg_data_i;
    end
  end

  // Pipeline stages A and B; a stalled stage keeps its contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_valid <= 1'b0;
      a_idx   <= '0;
      a_err   <= 1'b0;
      b_valid <= 1'b0;
      b_value <= '0;
      b_err   <= 1'b0;
    end else begin
      if (a_ready) begin
        a_valid <= in_valid_i;
        if (in_valid_i) begin
          a_idx <= a_idx_c;
          a_err <= a_err_c;
        end
      end
      if (b_ready) begin
        b_valid <= a_valid;
        if (a_valid) begin
          b_value <= a_err ? '0 : tbl[a_idx];
          b_err   <= a_err;
        end
      end
    end
  end

  // Saturating count of errored codes actually handed to the consumer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt <= '0;
    end else if (b_valid && out_ready_i && b_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNTW'(1);
    end
  end

  assign in_ready_o  = a_ready;
  assign out_valid_o = b_valid;
  assign value_o     = b_value;
  assign err_o       = b_err;
  assign err_cnt_o   = err_cnt;

endmodule

// File: tb/tb_interval_decode.sv
// Bench for interval_decode (FP8 entries, 8 bins, 8-bit error counter).
// Inputs change 1ns after the rising edge; outputs are observed on the falling
// edge. A monitor pairs every delivered output with the oldest entry of an
// expected queue that the driver fills from the bench's own centroid table.
module tb_interval_decode;

  localparam int W = 8;
  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         cfg_we;
  logic [2:0]   cfg_addr;
  logic [W-1:0] cfg_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] interval;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] value;
  logic         err;
  logic [7:0]   err_cnt;

  interval_decode #(.FpFormat(3), .NUM(N), .CNTW(8)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .interval_i (interval),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .value_o    (value),
    .err_o      (err),
    .err_cnt_o  (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [W:0]   exp_q[$];        // {err, value}
  logic [W-1:0] model_tbl [N];
  int           exp_cnt;
  int           n_checks;
  int           n_fail;

  typedef struct {
    logic [N-1:0] code;
    logic [W-1:0] exp_value;
    logic         exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Expected centroid for a code, from the bench's table.
  function automatic logic [W:0] model(input logic [N-1:0] code);
    int ones = 0;
    int pos = 0;
    for (int i = 0; i < N; i++) begin
      if (code[i]) begin
        ones++;
        pos = i;
      end
    end
    if (ones != 1) return {1'b1, {W{1'b0}}};
    return {1'b0, model_tbl[pos]};
  endfunction

  // Monitor: a handshake seen here completes on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(value), 32'hdead);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("out_value", 32'(value), 32'(e[W-1:0]));
        check("out_err", 32'(err), 32'(e[W]));
        if (err && exp_cnt < 255) exp_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] code, input logic [W:0] e);
    int waits = 0;
    interval = code;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [N-1:0] code);
    send(code, model(code));
  endtask

  task automatic write_cfg(input logic [2:0] addr, input logic [W-1:0] data);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    model_tbl[addr] = data;
  endtask

  task automatic drain;
    int waits = 0;
    while (exp_q.size() != 0 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_cnt = 0;
    for (int i = 0; i < N; i++) model_tbl[i] = '0;
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    in_valid = 1'b0;
    interval = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Zero table: stream every bin; first result appears after the second edge
    send(8'h01, {1'b0, 8'h00});
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    send(8'h02, {1'b0, 8'h00});
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_value", 32'(value), 32'd0);
    for (int i = 2; i < N; i++) send(8'(1 << i), {1'b0, 8'h00});
    drain();

    // Malformed codes decode to zero and bump the counter one at a time
    send(8'h00, {1'b1, 8'h00});
    drain();
    check("err_cnt_first", 32'(err_cnt), 32'd1);
    send(8'h81, {1'b1, 8'h00});
    drain();
    check("err_cnt_second", 32'(err_cnt), 32'd2);

    // Programmed table, single lookup then a vector table
    for (int i = 0; i < N; i++) write_cfg(3'(i), 8'(8'h10 + i));
    send(8'h08, {1'b0, 8'h13});
    drain();
    for (int i = 0; i < 8; i++) begin
      vecs[i].code = 8'(1 << i);
      vecs[i].exp_value = 8'(8'h10 + i);
      vecs[i].exp_err = 1'b0;
    end
    vecs[8]  = '{code: 8'h00, exp_value: 8'h00, exp_err: 1'b1};
    vecs[9]  = '{code: 8'hFF, exp_value: 8'h00, exp_err: 1'b1};
    vecs[10] = '{code: 8'h40, exp_value: 8'h16, exp_err: 1'b0};
    vecs[11] = '{code: 8'h18, exp_value: 8'h00, exp_err: 1'b1};
    for (int i = 0; i < 12; i++) send(vecs[i].code, {vecs[i].exp_err, vecs[i].exp_value});
    drain();
    check("err_cnt_after_vecs", 32'(err_cnt), 32'd5);

    // Backpressure: only two codes fit, output holds steady, then all drain in order
    begin
      logic [N-1:0] codes [5];
      int idx = 0;
      codes[0] = 8'h01; codes[1] = 8'h02; codes[2] = 8'h04; codes[3] = 8'h08; codes[4] = 8'h10;
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
        in_valid = 1'b1;
        interval = codes[idx];
        @(negedge clk);
        if (in_ready) begin
          exp_q.push_back(model(codes[idx]));
          idx++;
        end
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      check("bp_accepted", 32'(idx), 32'd2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_value_hold1", 32'(value), 32'h10);
      repeat (3) @(posedge clk);
      #1;
      check("bp_value_hold2", 32'(value), 32'h10);
      check("bp_err_hold", 32'(err), 32'd0);
      out_ready = 1'b1;
      while (idx < 5) begin
        send_model(codes[idx]);
        idx++;
      end
      drain();
    end

    // Same-edge write and lookup of entry 3 sees the old value
    send(8'h08, {1'b0, 8'h13});
    cfg_we = 1'b1;
    cfg_addr = 3'd3;
    cfg_data = 8'h55;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    model_tbl[3] = 8'h55;
    send(8'h08, {1'b0, 8'h55});
    send_model(8'h04);
    drain();

    // Counter saturation
    for (int i = 0; i < 300; i++) send(8'h03, {1'b1, 8'h00});
    drain();
    check("err_cnt_sat", 32'(err_cnt), 32'hFF);
    check("err_cnt_model", 32'(err_cnt), 32'(exp_cnt));

    // Reset with two codes in flight
    out_ready = 1'b0;
    send(8'h01, {1'b0, 8'h10});
    send(8'h02, {1'b0, 8'h11});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    for (int i = 0; i < N; i++) model_tbl[i] = '0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) send(8'(1 << i), {1'b0, 8'h00});
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
